// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: src0 (ALU/load) vs src1 (mul/div), with a src1 pending-write scoreboard.
// Latency: a grant in cycle N shows up as RegWrite/WriteReg/WriteData in cycle N+1; ready is combinational.
// Backpressure: src0 has fixed priority; src1 gets one forced grant after STARVE_LIMIT denials; the port never stalls.
// Optional feature macro WB_BYPASS_EN adds byp_valid/byp_reg/byp_data forwarding outputs.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_REGS     = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                src0_valid,
    input  logic [4:0]          src0_reg,
    input  logic [31:0]         src0_data,
    output logic                src0_ready,
    input  logic                src1_valid,
    input  logic [4:0]          src1_reg,
    input  logic [31:0]         src1_data,
    output logic                src1_ready,
    input  logic                sb_set,
    input  logic [4:0]          sb_reg,
    output logic [NUM_REGS-1:0] sb_busy,
    output logic                RegWrite,
    output logic [4:0]          WriteReg,
    output logic [31:0]         WriteData
`ifdef WB_BYPASS_EN
    ,
    output logic                byp_valid,
    output logic [4:0]          byp_reg,
    output logic [31:0]         byp_data
`endif
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]    starveCnt;
    logic [CNT_W-1:0]    starveInc;
    logic                forceGrant;
    logic                xfer0;
    logic                xfer1;
    logic                wbSrc1;
    logic [NUM_REGS-1:0] busyNext;

    // Force only overrides src0 when src1 actually has something to write.
    assign src0_ready = src0_valid & ~(forceGrant & src1_valid);
    assign src1_ready = src1_valid & (~src0_valid | forceGrant);
    assign xfer0      = src0_valid & src0_ready;
    assign xfer1      = src1_valid & src1_ready;

    // Saturating increment of the denial count.
    assign starveInc = (starveCnt == LIMIT) ? starveCnt : starveCnt + 1'b1;

    // Starvation tracking: count consecutive src1 denials, arm a one-shot forced grant at the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starveCnt  <= '0;
            forceGrant <= 1'b0;
        end else if (xfer1) begin
            starveCnt  <= '0;
            forceGrant <= 1'b0;
        end else if (src1_valid) begin
            starveCnt <= starveInc;
            if (starveInc == LIMIT) begin
                forceGrant <= 1'b1;
            end
        end else begin
            // An idle src1 resets the streak; an armed force waits for the next src1 grant.
            starveCnt <= '0;
        end
    end

    // Output register: capture the winning write; register 0 is accepted but never enabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            wbSrc1    <= 1'b0;
        end else if (xfer0) begin
            RegWrite  <= (src0_reg != 5'd0);
            WriteReg  <= src0_reg;
            WriteData <= src0_data;
            wbSrc1    <= 1'b0;
        end else if (xfer1) begin
            RegWrite  <= (src1_reg != 5'd0);
            WriteReg  <= src1_reg;
            WriteData <= src1_data;
            wbSrc1    <= (src1_reg != 5'd0);
        end else begin
            RegWrite <= 1'b0;
            wbSrc1   <= 1'b0;
        end
    end

    // Scoreboard next state: commit of a src1 write clears its bit, a new issue sets it (set wins).
    always_comb begin
        busyNext = sb_busy;
        if (RegWrite && wbSrc1) begin
            busyNext[WriteReg] = 1'b0;
        end
        if (sb_set && (sb_reg != 5'd0)) begin
            busyNext[sb_reg] = 1'b1;
        end
    end

    // Scoreboard state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sb_busy <= '0;
        end else begin
            sb_busy <= busyNext;
        end
    end

`ifdef WB_BYPASS_EN
    // Forwarding view of the in-flight write; register 0 never forwards.
    assign byp_valid = RegWrite & (WriteReg != 5'd0);
    assign byp_reg   = WriteReg;
    assign byp_data  = WriteData;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios then randomized traffic against a reference model.
// Expected writeback slots are queued per cycle and checked by an independent monitor.
// The bench runs the default STARVE_LIMIT of 4.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        src0_valid = 1'b0;
    logic [4:0]  src0_reg = '0;
    logic [31:0] src0_data = '0;
    logic        src0_ready;
    logic        src1_valid = 1'b0;
    logic [4:0]  src1_reg = '0;
    logic [31:0] src1_data = '0;
    logic        src1_ready;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_reg = '0;
    logic [31:0] sb_busy;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
`ifdef WB_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_reg;
    logic [31:0] byp_data;
`endif

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT), .NUM_REGS(32)) dut (
        .clock(clock), .reset(reset),
        .src0_valid(src0_valid), .src0_reg(src0_reg), .src0_data(src0_data), .src0_ready(src0_ready),
        .src1_valid(src1_valid), .src1_reg(src1_reg), .src1_data(src1_data), .src1_ready(src1_ready),
        .sb_set(sb_set), .sb_reg(sb_reg), .sb_busy(sb_busy),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
`ifdef WB_BYPASS_EN
        , .byp_valid(byp_valid), .byp_reg(byp_reg), .byp_data(byp_data)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [4:0]  r;
        logic [31:0] d;
    } wbExp_t;

    wbExp_t      expQ[$];
    int          tests = 0;
    int          fails = 0;

    // Reference model state
    int          mDenied = 0;     // consecutive src1 denials
    bit          mForce = 0;      // src1 owed a forced grant
    logic [31:0] busyExp = '0;
    int          prevSrc1Reg = 0; // src1 write committing during the next cycle
    logic        lastRdy0, lastRdy1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus: checks last edge's scoreboard, drives inputs, checks grants, updates model.
    task automatic cycle(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                         input logic set, input logic [4:0] sr);
        int     win;
        wbExp_t e;
        @(negedge clock);
        chk("sb_busy", sb_busy, busyExp);
        src0_valid = v0; src0_reg = r0; src0_data = d0;
        src1_valid = v1; src1_reg = r1; src1_data = d1;
        sb_set = set; sb_reg = sr;
        #1;
        // Winner: an owed src1 grant first, otherwise src0 first, otherwise src1.
        if (v1 && mForce)  win = 1;
        else if (v0)       win = 0;
        else if (v1)       win = 1;
        else               win = -1;
        lastRdy0 = src0_ready;
        lastRdy1 = src1_ready;
        chk("src0_ready", {31'b0, src0_ready}, {31'b0, win == 0});
        chk("src1_ready", {31'b0, src1_ready}, {31'b0, win == 1});
        e.v = 1'b0; e.r = '0; e.d = '0;
        if (win == 0) begin e.v = (r0 != 0); e.r = r0; e.d = d0; end
        if (win == 1) begin e.v = (r1 != 0); e.r = r1; e.d = d1; end
        expQ.push_back(e);
        if (win == 1) begin
            mDenied = 0;
            mForce  = 0;
        end else if (v1) begin
            mDenied = (mDenied + 1 > LIMIT) ? LIMIT : mDenied + 1;
            if (mDenied == LIMIT) mForce = 1;
        end else begin
            mDenied = 0;
        end
        if (prevSrc1Reg != 0) busyExp[prevSrc1Reg] = 1'b0;
        if (set && sr != 0) busyExp[sr] = 1'b1;
        prevSrc1Reg = (win == 1) ? int'(r1) : 0;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: after each edge, compare the writeback port with the oldest queued slot.
    initial begin
        wbExp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (!reset && expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("RegWrite", {31'b0, RegWrite}, {31'b0, e.v});
                if (e.v) begin
                    chk("WriteReg", {27'b0, WriteReg}, {27'b0, e.r});
                    chk("WriteData", WriteData, e.d);
                end
`ifdef WB_BYPASS_EN
                chk("byp_valid", {31'b0, byp_valid}, {31'b0, e.v});
                if (e.v) chk("byp_data", byp_data, e.d);
`endif
            end
        end
    end

    initial begin
        // Reset state
        #12;
        chk("rst_RegWrite", {31'b0, RegWrite}, 32'd0);
        chk("rst_WriteReg", {27'b0, WriteReg}, 32'd0);
        chk("rst_WriteData", WriteData, 32'd0);
        chk("rst_sb_busy", sb_busy, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single write then idle
        cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        idle();
        idle();

        // Contention: src0 wins, then src1 alone wins
        cycle(1, 3, 32'h33, 1, 9, 32'h99, 0, 0);
        chk("contend_rdy1", {31'b0, lastRdy1}, 32'd0);
        cycle(0, 0, 0, 1, 9, 32'h99, 0, 0);
        chk("contend_rdy1_later", {31'b0, lastRdy1}, 32'd1);

        // Starvation: four denials, forced grant on the fifth, src0 again on the sixth
        for (int i = 1; i <= 6; i++) begin
            cycle(1, 5'(i + 1), 32'h100 + i, 1, 5'(i + 10), 32'h200 + i, 0, 0);
            chk($sformatf("starve_rdy1_c%0d", i), {31'b0, lastRdy1}, {31'b0, i == 5});
            chk($sformatf("starve_rdy0_c%0d", i), {31'b0, lastRdy0}, {31'b0, i != 5});
        end
        idle();

        // Register 0 accepted but not written
        cycle(1, 0, 32'h1, 0, 0, 0, 0, 0);
        chk("reg0_rdy0", {31'b0, lastRdy0}, 32'd1);
        idle();

        // Scoreboard: set, commit clears, then set coinciding with commit stays busy
        cycle(0, 0, 0, 0, 0, 0, 1, 12);
        cycle(0, 0, 0, 1, 12, 32'hC0DE, 0, 0);
        chk("sb12_set", {31'b0, sb_busy[12]}, 32'd1);
        idle();
        idle();
        chk("sb12_cleared", {31'b0, sb_busy[12]}, 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 1, 12);
        cycle(0, 0, 0, 1, 12, 32'hC0DF, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 12);
        idle();
        chk("sb12_set_wins", {31'b0, sb_busy[12]}, 32'd1);
        cycle(0, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 99) < 60), 5'($urandom), $urandom,
                  ($urandom_range(0, 99) < 50), 5'($urandom), $urandom,
                  ($urandom_range(0, 99) < 30), 5'($urandom));
        end

        // Asynchronous reset while a write is in flight
        cycle(0, 0, 0, 0, 0, 0, 1, 20);
        cycle(1, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
        @(posedge clock);
        #2;
        chk("pre_rst_RegWrite", {31'b0, RegWrite}, 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_RegWrite", {31'b0, RegWrite}, 32'd0);
        chk("arst_sb_busy", sb_busy, 32'd0);
        expQ.delete();
        mDenied = 0; mForce = 0; busyExp = '0; prevSrc1Reg = 0;
        src0_valid = 0; src1_valid = 0; sb_set = 0;
        @(negedge clock);
        reset = 1'b0;
        cycle(1, 4, 32'h44, 0, 0, 0, 0, 0);
        idle();
        idle();
        @(negedge clock);
        chk("final_queue_empty", expQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
